// File: rtl/round_ring_pipe.sv
// round_ring_pipe: a ring of STAGES registered round stages. Each stage has
// its own round key. Each accepted block makes PASSES laps of the ring and
// then leaves through a registered output port. Up to STAGES blocks can be
// in flight at once. Each block carries its own valid bit, pass counter and
// tag. The output has no backpressure.
module round_ring_pipe #(
    parameter int                       WIDTH      = 640,
    parameter int                       KEY_W      = 20,
    parameter int                       STAGES     = 4,
    parameter int                       PASSES     = 1,
    parameter int                       ROT        = 1,
    parameter logic [STAGES*KEY_W-1:0]  ROUND_KEYS = {20'hFEDCB, 20'hABCDE, 20'h67890, 20'h12345},
    parameter int                       TAG_W      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                in_data,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [TAG_W-1:0]                out_tag,
    output logic                            out_valid,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int TL    = STAGES - 1;
    localparam int P_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int REPS  = WIDTH / KEY_W;

    localparam logic [P_W-1:0]   P_LAST  = P_W'(PASSES - 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    // Left rotation by the compile-time amount ROT. It is written as a window
    // over the doubled word, so ROT=0 gives a plain pass-through.
    function automatic logic [WIDTH-1:0] rotl_f(input logic [WIDTH-1:0] x);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x};
        return dbl[2*WIDTH-1-ROT -: WIDTH];
    endfunction

    // Round k: rotate left, then XOR with round key k repeated across the word.
    function automatic logic [WIDTH-1:0] round_f(input logic [WIDTH-1:0] x, input int k);
        logic [KEY_W-1:0] key;
        key = ROUND_KEYS[k*KEY_W +: KEY_W];
        return rotl_f(x) ^ {REPS{key}};
    endfunction

    // Slot state. Data and tag are don't-care while the slot's valid bit is clear.
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [P_W-1:0]    p_q    [STAGES];
    logic [STAGES-1:0] vld_q;

    logic [WIDTH-1:0]  rnd_d  [STAGES];

    logic [WIDTH-1:0]  s0_data_d;
    logic [TAG_W-1:0]  s0_tag_d;
    logic [P_W-1:0]    s0_p_d;
    logic              s0_vld_d;

    logic [WIDTH-1:0]  out_data_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_valid_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    logic              tail_final;
    logic              accept;

    // Each slot's round output. The tail's result is either the finished
    // block or the data that goes back into slot 0.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            rnd_d[k] = round_f(data_q[k], k);
        end
    end

    assign tail_final = vld_q[TL] && (p_q[TL] == P_LAST);
    // Built only from registered state, so in_valid cannot loop back into in_ready.
    assign in_ready   = !vld_q[TL] || tail_final;
    assign accept     = in_valid && in_ready;

    // Slot 0 entry. A block that recirculates takes priority. Otherwise a new
    // input is loaded raw, and round 0 is applied on the way into slot 1.
    always_comb begin
        s0_data_d = in_data;
        s0_tag_d  = in_tag;
        s0_vld_d  = in_valid;
        s0_p_d    = '0;
        if (vld_q[TL] && !tail_final) begin
            s0_data_d = rnd_d[TL];
            s0_tag_d  = tag_q[TL];
            s0_vld_d  = 1'b1;
            s0_p_d    = p_q[TL] + P_W'(1);
        end
    end

    // Occupancy: an exit and an accept on the same edge cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({accept, tail_final})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Control state and output port. Reset drops every in-flight block.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                p_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            occ_q       <= '0;
        end else begin
            for (int k = 0; k < TL; k++) begin
                vld_q[k+1] <= vld_q[k];
                p_q[k+1]   <= p_q[k];
            end
            vld_q[0]    <= s0_vld_d;
            p_q[0]      <= s0_p_d;
            out_valid_q <= tail_final;
            if (tail_final) begin
                out_data_q <= rnd_d[TL];
                out_tag_q  <= tag_q[TL];
            end
            occ_q       <= occ_d;
        end
    end

    // Datapath shift around the ring. No reset is needed because each slot's
    // valid bit qualifies its data.
    always_ff @(posedge clk) begin
        for (int k = 0; k < TL; k++) begin
            data_q[k+1] <= rnd_d[k];
            tag_q[k+1]  <= tag_q[k];
        end
        data_q[0] <= s0_data_d;
        tag_q[0]  <= s0_tag_d;
    end

    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;

endmodule
